rf_wb_arbiter: RTL

//  Shares the register bank's single write port (regWrite/a3/wd3) between two writeback sources: ALU and load unit (MEM).

---
 rtl/rv_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared register-file constants and writeback source encoding used by the
// writeback arbiter and its scoreboard.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set when decode issues
// a writer and cleared once the register bank has latched the write.
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            clr_valid,
    input  logic [AW-1:0]   clr_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic            stall,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] busy_next;

    assign stall = (rs1_used && busy[rs1]) || (rs2_used && busy[rs2]);

    // Set is applied after clear so a newer pending writer survives a same-edge writeback.
    always_comb begin
        busy_next = busy;
        if (clr_valid) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (iss_valid && !stall && iss_rd != REG_ZERO) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU
// and load-unit writeback paths, with a registered write port and busy scoreboard.
module rf_wb_arbiter
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic            stall,
    output logic            regWrite,
    output logic [AW-1:0]   a3,
    output logic [XLEN-1:0] wd3,
    output logic [NREG-1:0] busy
);
    // Handshake: a source asserts valid with stable rd/data; the transfer
    // completes in the cycle its ready is high, and it may then move on.
    src_e            last_grant;
    logic            grant_alu;
    logic            grant_mem;
    logic            grant_any;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            wr_q;
    logic [AW-1:0]   a3_q;
    logic [XLEN-1:0] wd3_q;

    assign grant_alu = !rst && alu_valid && (!mem_valid || last_grant == SRC_MEM);
    assign grant_mem = !rst && mem_valid && (!alu_valid || last_grant == SRC_ALU);
    assign grant_any = grant_alu || grant_mem;
    assign win_rd    = grant_alu ? alu_rd   : mem_rd;
    assign win_data  = grant_alu ? alu_data : mem_data;

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // Only contended grants move the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_MEM;
        end else if (grant_alu && mem_valid) begin
            last_grant <= SRC_ALU;
        end else if (grant_mem && alu_valid) begin
            last_grant <= SRC_MEM;
        end
    end

    // A grant to x0 leaves a3/wd3 untouched and produces no bank write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else if (grant_any && win_rd != REG_ZERO) begin
            wr_q  <= 1'b1;
            a3_q  <= win_rd;
            wd3_q <= win_data;
        end else begin
            wr_q  <= 1'b0;
        end
    end

    // Reset must also kill a write already sitting in the output registers.
    assign regWrite = wr_q && !rst;
    assign a3       = a3_q;
    assign wd3      = wd3_q;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_valid (regWrite),
        .clr_rd    (a3),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used),
        .stall     (stall),
        .busy      (busy)
    );
endmodule
